// File: rtl/load_store_full_monitor.sv
// Rise detector and period meter for the load/store volume-full signal.
// Each rise is offered over valid/ready, and a watchdog flags a missing rise.
module load_store_full_monitor #(
    parameter int PERIOD_MAX = 60000,
    parameter int TBITS      = 16,
    parameter int EVBITS     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [TBITS-1:0]  ev_period,
    output logic [EVBITS-1:0] ev_count,
    output logic              timeout,
    output logic              overrun
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [TBITS:0] PMAX_W = (TBITS+1)'(PERIOD_MAX);

    state_e             state_q, state_d;
    logic               sig_q;
    logic [TBITS-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic [TBITS-1:0]   ev_period_q, ev_period_d;
    logic [EVBITS-1:0]  ev_count_q, ev_count_d;
    logic               rise_s;
    logic [TBITS:0]     cnt_inc_s;
    logic [TBITS-1:0]   period_sat_s;
    logic               bound_hit_s;

    // One extra bit on the increment so the saturation compare cannot wrap.
    assign rise_s       = sig & ~sig_q;
    assign cnt_inc_s    = {1'b0, cnt_q} + (TBITS+1)'(1'b1);
    assign bound_hit_s  = (cnt_inc_s >= PMAX_W);
    assign period_sat_s = bound_hit_s ? PMAX_W[TBITS-1:0] : cnt_inc_s[TBITS-1:0];

    // Period counter and watchdog next state; a rise always wins.
    always_comb begin
        cnt_d     = period_sat_s;
        timeout_d = timeout_q;
        if (rise_s) begin
            cnt_d     = {TBITS{1'b0}};
            timeout_d = 1'b0;
        end else if (bound_hit_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            sig_q       <= 1'b0;
            cnt_q       <= {TBITS{1'b0}};
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            ev_period_q <= {TBITS{1'b0}};
            ev_count_q  <= {EVBITS{1'b0}};
        end else begin
            state_q     <= state_d;
            sig_q       <= sig;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            ev_period_q <= ev_period_d;
            ev_count_q  <= ev_count_d;
        end
    end

    // Next-state: a slot is freed only by an accept without a new rise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (rise_s) state_d = ST_FULL;
                else        state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (ev_ready && !rise_s) state_d = ST_EMPTY;
                else                     state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Event load / drop decisions; a rise into an unaccepted slot is lost.
    always_comb begin
        ev_period_d = ev_period_q;
        ev_count_d  = ev_count_q;
        overrun_d   = overrun_q;
        case (state_q)
            ST_EMPTY: begin
                if (rise_s) begin
                    ev_period_d = period_sat_s;
                    ev_count_d  = ev_count_q + EVBITS'(1'b1);
                end else begin
                    ev_period_d = ev_period_q;
                end
            end
            ST_FULL: begin
                if (rise_s && ev_ready) begin
                    ev_period_d = period_sat_s;
                    ev_count_d  = ev_count_q + EVBITS'(1'b1);
                end else if (rise_s) begin
                    overrun_d   = 1'b1;
                end else begin
                    ev_period_d = ev_period_q;
                end
            end
            default: begin
                ev_period_d = ev_period_q;
            end
        endcase
    end

    assign ev_valid  = (state_q == ST_FULL);
    assign ev_period = ev_period_q;
    assign ev_count  = ev_count_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_load_store_full_monitor.sv
// Directed bench for load_store_full_monitor with PERIOD_MAX=20, TBITS=5, EVBITS=3.
module tb_load_store_full_monitor;

    logic       clk;
    logic       rst;
    logic       sig;
    logic       ev_valid;
    logic       ev_ready;
    logic [4:0] ev_period;
    logic [2:0] ev_count;
    logic       timeout;
    logic       overrun;

    int checks_q;
    int errors_q;

    load_store_full_monitor #(
        .PERIOD_MAX(20),
        .TBITS     (5),
        .EVBITS    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_period(ev_period),
        .ev_count (ev_count),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, then release at a falling edge so the next rising edge is cycle 1.
    task automatic do_reset();
        rst      = 1'b0;
        sig      = 1'b0;
        ev_ready = 1'b0;
        tick(2);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks_q = 0;
        errors_q = 0;

        // Reset state, single-cycle pulse on cycle 5
        do_reset();
        chk("rst_valid",   {31'd0, ev_valid}, 32'd0);
        chk("rst_period",  {27'd0, ev_period}, 32'd0);
        chk("rst_count",   {29'd0, ev_count}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        ev_ready = 1'b1;
        tick(4);
        sig = 1'b1;
        tick(1);
        sig = 1'b0;
        chk("p1_valid",   {31'd0, ev_valid}, 32'd1);
        chk("p1_period",  {27'd0, ev_period}, 32'd5);
        chk("p1_count",   {29'd0, ev_count}, 32'd1);
        chk("p1_timeout", {31'd0, timeout}, 32'd0);
        tick(1);
        chk("p1_valid_drop", {31'd0, ev_valid}, 32'd0);

        // Two-cycle-high levels on cycles 8..9 and 16..17
        do_reset();
        ev_ready = 1'b1;
        tick(7);
        sig = 1'b1;
        tick(1);
        chk("lv1_period", {27'd0, ev_period}, 32'd8);
        chk("lv1_count",  {29'd0, ev_count}, 32'd1);
        tick(1);
        chk("lv1_hold_valid", {31'd0, ev_valid}, 32'd0);
        sig = 1'b0;
        tick(6);
        sig = 1'b1;
        tick(1);
        chk("lv2_valid",  {31'd0, ev_valid}, 32'd1);
        chk("lv2_period", {27'd0, ev_period}, 32'd8);
        chk("lv2_count",  {29'd0, ev_count}, 32'd2);
        tick(1);
        sig = 1'b0;
        chk("lv2_hold_valid", {31'd0, ev_valid}, 32'd0);
        chk("lv2_hold_count", {29'd0, ev_count}, 32'd2);

        // Overrun: rises on cycles 4 and 10 with ev_ready low
        do_reset();
        tick(3);
        sig = 1'b1;
        tick(1);
        sig = 1'b0;
        chk("ov_first_period", {27'd0, ev_period}, 32'd4);
        chk("ov_pre_overrun",  {31'd0, overrun}, 32'd0);
        tick(5);
        sig = 1'b1;
        tick(1);
        sig = 1'b0;
        chk("ov_valid",   {31'd0, ev_valid}, 32'd1);
        chk("ov_period",  {27'd0, ev_period}, 32'd4);
        chk("ov_count",   {29'd0, ev_count}, 32'd1);
        chk("ov_overrun", {31'd0, overrun}, 32'd1);
        ev_ready = 1'b1;
        tick(1);
        chk("ov_accept_valid",  {31'd0, ev_valid}, 32'd0);
        chk("ov_sticky",        {31'd0, overrun}, 32'd1);

        // Back-to-back: rise on cycle 5 while the cycle-3 event is accepted
        do_reset();
        ev_ready = 1'b1;
        tick(2);
        sig = 1'b1;
        tick(1);
        chk("bb1_period", {27'd0, ev_period}, 32'd3);
        sig      = 1'b0;
        ev_ready = 1'b0;
        tick(1);
        chk("bb_hold_valid", {31'd0, ev_valid}, 32'd1);
        sig      = 1'b1;
        ev_ready = 1'b1;
        tick(1);
        sig = 1'b0;
        chk("bb2_valid",   {31'd0, ev_valid}, 32'd1);
        chk("bb2_period",  {27'd0, ev_period}, 32'd2);
        chk("bb2_count",   {29'd0, ev_count}, 32'd2);
        chk("bb2_overrun", {31'd0, overrun}, 32'd0);

        // Watchdog and saturation, then asynchronous reset mid-handshake
        do_reset();
        tick(18);
        chk("wd_early", {31'd0, timeout}, 32'd0);
        tick(2);
        chk("wd_fire", {31'd0, timeout}, 32'd1);
        tick(9);
        sig = 1'b1;
        tick(1);
        sig = 1'b0;
        chk("wd_sat_period", {27'd0, ev_period}, 32'd20);
        chk("wd_clear",      {31'd0, timeout}, 32'd0);
        tick(20);
        chk("ar_pre_valid",   {31'd0, ev_valid}, 32'd1);
        chk("ar_pre_timeout", {31'd0, timeout}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_valid",   {31'd0, ev_valid}, 32'd0);
        chk("ar_period",  {27'd0, ev_period}, 32'd0);
        chk("ar_count",   {29'd0, ev_count}, 32'd0);
        chk("ar_timeout", {31'd0, timeout}, 32'd0);
        chk("ar_overrun", {31'd0, overrun}, 32'd0);

        // Nine rises two cycles apart: count wraps modulo 8 to 1
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sig = 1'b1;
            tick(1);
            sig = 1'b0;
            if (i == 8) begin
                chk("wrap_count",  {29'd0, ev_count}, 32'd1);
                chk("wrap_period", {27'd0, ev_period}, 32'd2);
            end
            tick(1);
        end
        chk("wrap_idle_valid", {31'd0, ev_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
